// File: rtl/crc32_stream.sv
// Streaming CRC-32 generator / FCS checker with valid/ready beats and sof/last framing.
// One beat of DATA_W bits is folded per cycle; the per-frame result is held until taken.
module crc32_stream #(
  parameter int          DATA_W      = 4,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter logic [31:0] RESIDUE     = 32'hC704DD7B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_last,
  input  logic              s_abort,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_crc,
  output logic              m_fcs_ok,
  output logic [15:0]       m_len
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] len_reg, len_next;
  logic [31:0] m_crc_reg, m_crc_next;
  logic        m_fcs_ok_reg, m_fcs_ok_next;
  logic [15:0] m_len_reg, m_len_next;

  logic              accept;
  logic              start_frame;
  logic [DATA_W-1:0] data_ord;
  logic [31:0]       step [0:DATA_W];
  logic [31:0]       beat_crc;
  logic [31:0]       beat_crc_rev;
  logic [31:0]       beat_result;
  logic [15:0]       beat_len;

  assign s_ready     = (state_reg != HOLD);
  assign m_valid     = (state_reg == HOLD);
  assign m_crc       = m_crc_reg;
  assign m_fcs_ok    = m_fcs_ok_reg;
  assign m_len       = m_len_reg;
  assign accept      = s_valid && s_ready;
  assign start_frame = (state_reg == IDLE) || s_sof;

  // Serial LFSR unrolled across the beat; data_ord[0] is the first bit shifted in.
  assign step[0] = start_frame ? INIT : crc_reg;
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
      assign data_ord[gi] = REFLECT_IN ? s_data[gi] : s_data[DATA_W-1-gi];
      assign step[gi+1]   = {step[gi][30:0], 1'b0} ^
                            ((step[gi][31] ^ data_ord[gi]) ? POLY : 32'h0);
    end
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
      assign beat_crc_rev[gi] = beat_crc[31-gi];
    end
  endgenerate

  assign beat_crc    = step[DATA_W];
  assign beat_result = (REFLECT_OUT ? beat_crc_rev : beat_crc) ^ XOR_OUT;
  assign beat_len    = start_frame ? 16'd1 :
                       (len_reg == 16'hFFFF) ? 16'hFFFF : len_reg + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      crc_reg      <= INIT;
      len_reg      <= 16'd0;
      m_crc_reg    <= 32'h0;
      m_fcs_ok_reg <= 1'b0;
      m_len_reg    <= 16'd0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      len_reg      <= len_next;
      m_crc_reg    <= m_crc_next;
      m_fcs_ok_reg <= m_fcs_ok_next;
      m_len_reg    <= m_len_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    crc_next      = crc_reg;
    len_next      = len_reg;
    m_crc_next    = m_crc_reg;
    m_fcs_ok_next = m_fcs_ok_reg;
    m_len_next    = m_len_reg;
    case (state_reg)
      IDLE: begin
        // Abort wins over a simultaneous sof beat; beats without sof are dropped.
        if (!s_abort && accept && s_sof) begin
          crc_next   = beat_crc;
          len_next   = beat_len;
          state_next = s_last ? HOLD : RUN;
        end
      end
      RUN: begin
        if (s_abort) begin
          state_next = IDLE;
          crc_next   = INIT;
          len_next   = 16'd0;
        end else if (accept) begin
          crc_next = beat_crc;
          len_next = beat_len;
          if (s_last) state_next = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_next = IDLE;
          crc_next   = INIT;
          len_next   = 16'd0;
        end
      end
      default: state_next = IDLE;
    endcase
    // Result is captured only on the transition into HOLD.
    if (state_reg != HOLD && state_next == HOLD) begin
      m_crc_next    = beat_result;
      m_fcs_ok_next = (beat_crc == RESIDUE);
      m_len_next    = beat_len;
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: an 8-bit and a 4-bit instance with default CRC-32 settings.
module tb_crc32_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s_valid8, s_ready8, s_sof8, s_last8, s_abort8;
  logic [7:0]  s_data8;
  logic        m_valid8, m_ready8, m_fcs_ok8;
  logic [31:0] m_crc8;
  logic [15:0] m_len8;

  logic        s_valid4, s_ready4, s_sof4, s_last4, s_abort4;
  logic [3:0]  s_data4;
  logic        m_valid4, m_ready4, m_fcs_ok4;
  logic [31:0] m_crc4;
  logic [15:0] m_len4;

  crc32_stream #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .s_sof(s_sof8), .s_last(s_last8), .s_abort(s_abort8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_crc(m_crc8),
    .m_fcs_ok(m_fcs_ok8), .m_len(m_len8)
  );

  crc32_stream #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .s_sof(s_sof4), .s_last(s_last4), .s_abort(s_abort4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_crc(m_crc4),
    .m_fcs_ok(m_fcs_ok4), .m_len(m_len4)
  );

  int checks = 0;
  int errors = 0;
  int stall_to = 0;
  logic [7:0] buf8 [0:15];

  // Drivers start and end 1 ns after a rising edge.
  task automatic beat8(input logic [7:0] d, input logic sof, input logic last, input logic abort);
    int n;
    s_valid8 = 1'b1; s_data8 = d; s_sof8 = sof; s_last8 = last; s_abort8 = abort;
    n = 0;
    while (!s_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!s_ready8) stall_to++;
    @(posedge clk); #1;
    s_valid8 = 1'b0; s_sof8 = 1'b0; s_last8 = 1'b0; s_abort8 = 1'b0;
  endtask

  task automatic beat4(input logic [3:0] d, input logic sof, input logic last);
    int n;
    s_valid4 = 1'b1; s_data4 = d; s_sof4 = sof; s_last4 = last;
    n = 0;
    while (!s_ready4 && n < 50) begin @(posedge clk); #1; n++; end
    if (!s_ready4) stall_to++;
    @(posedge clk); #1;
    s_valid4 = 1'b0; s_sof4 = 1'b0; s_last4 = 1'b0;
  endtask

  task automatic frame8(input int len);
    for (int i = 0; i < len; i++) beat8(buf8[i], i == 0, i == len - 1, 1'b0);
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) buf8[i] = 8'h31 + 8'(i);
  endtask

  task automatic collect8(output logic [31:0] crc, output logic [15:0] len,
                          output logic ok, output logic to);
    int n;
    n = 0;
    while (!m_valid8 && n < 50) begin @(posedge clk); #1; n++; end
    to = !m_valid8; crc = m_crc8; len = m_len8; ok = m_fcs_ok8;
    m_ready8 = 1'b1; @(posedge clk); #1; m_ready8 = 1'b0;
  endtask

  task automatic collect4(output logic [31:0] crc, output logic [15:0] len, output logic to);
    int n;
    n = 0;
    while (!m_valid4 && n < 50) begin @(posedge clk); #1; n++; end
    to = !m_valid4; crc = m_crc4; len = m_len4;
    m_ready4 = 1'b1; @(posedge clk); #1; m_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (m_valid8 !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b want=0", m_valid8); end
    checks++; if (m_crc8 !== 32'h0) begin errors++; $display("FAIL reset_m_crc got=%h want=00000000", m_crc8); end
    checks++; if (m_len8 !== 16'd0) begin errors++; $display("FAIL reset_m_len got=%0d want=0", m_len8); end
    checks++; if (m_fcs_ok8 !== 1'b0) begin errors++; $display("FAIL reset_m_fcs_ok got=%b want=0", m_fcs_ok8); end
    checks++; if (s_ready8 !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b want=1", s_ready8); end
    checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL reset_m_valid4 got=%b want=0", m_valid4); end
    $display("reset: m_valid=%b m_crc=%h m_len=%0d s_ready=%b", m_valid8, m_crc8, m_len8, s_ready8);
  endtask

  task automatic test_basic8();
    logic [31:0] crc; logic [15:0] len; logic ok, to;
    load_digits();
    frame8(9);
    checks++; if (m_valid8 !== 1'b1) begin errors++; $display("FAIL basic_latency m_valid got=%b want=1", m_valid8); end
    collect8(crc, len, ok, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b want=0", to); end
    checks++; if (crc !== 32'hCBF43926) begin errors++; $display("FAIL basic_crc got=%h want=cbf43926", crc); end
    checks++; if (len !== 16'd9) begin errors++; $display("FAIL basic_len got=%0d want=9", len); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL basic_fcs_ok got=%b want=0", ok); end
    $display("basic8: crc=%h len=%0d fcs_ok=%b", crc, len, ok);
  endtask

  task automatic test_nibble4();
    logic [31:0] crc; logic [15:0] len; logic to; logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      b = 8'h31 + 8'(i);
      beat4(b[3:0], i == 0, 1'b0);
      beat4(b[7:4], 1'b0, i == 8);
    end
    collect4(crc, len, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nibble_timeout got=%b want=0", to); end
    checks++; if (crc !== 32'hCBF43926) begin errors++; $display("FAIL nibble_crc got=%h want=cbf43926", crc); end
    checks++; if (len !== 16'd18) begin errors++; $display("FAIL nibble_len got=%0d want=18", len); end
    $display("nibble4: crc=%h len=%0d", crc, len);
  endtask

  task automatic test_fcs();
    logic [31:0] crc; logic [15:0] len; logic ok, to;
    load_digits();
    buf8[9] = 8'h26; buf8[10] = 8'h39; buf8[11] = 8'hF4; buf8[12] = 8'hCB;
    frame8(13);
    collect8(crc, len, ok, to);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fcs_good_ok got=%b want=1", ok); end
    checks++; if (len !== 16'd13) begin errors++; $display("FAIL fcs_good_len got=%0d want=13", len); end
    checks++; if (crc !== 32'h2144DF1C) begin errors++; $display("FAIL fcs_good_crc got=%h want=2144df1c", crc); end
    $display("fcs good: crc=%h len=%0d fcs_ok=%b", crc, len, ok);
    buf8[0] = 8'h30;
    frame8(13);
    collect8(crc, len, ok, to);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL fcs_bad_ok got=%b want=0", ok); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL fcs_bad_timeout got=%b want=0", to); end
    $display("fcs flipped: crc=%h len=%0d fcs_ok=%b", crc, len, ok);
  endtask

  task automatic test_back_to_back();
    logic [31:0] crc; logic [15:0] len; logic ok, to;
    load_digits();
    frame8(9);
    // Next frame's single sof+last beat waits on the bus while the result is stalled.
    s_valid8 = 1'b1; s_data8 = 8'h00; s_sof8 = 1'b1; s_last8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (s_ready8 !== 1'b0) begin errors++; $display("FAIL hold_s_ready cyc=%0d got=%b want=0", c, s_ready8); end
      checks++; if (m_valid8 !== 1'b1) begin errors++; $display("FAIL hold_m_valid cyc=%0d got=%b want=1", c, m_valid8); end
      checks++; if (m_crc8 !== 32'hCBF43926 || m_len8 !== 16'd9)
        begin errors++; $display("FAIL hold_stable cyc=%0d got=%h/%0d want=cbf43926/9", c, m_crc8, m_len8); end
      @(posedge clk); #1;
    end
    m_ready8 = 1'b1; @(posedge clk); #1; m_ready8 = 1'b0;
    checks++; if (m_valid8 !== 1'b0) begin errors++; $display("FAIL b2b_after_hs_valid got=%b want=0", m_valid8); end
    checks++; if (s_ready8 !== 1'b1) begin errors++; $display("FAIL b2b_after_hs_ready got=%b want=1", s_ready8); end
    @(posedge clk); #1;
    s_valid8 = 1'b0; s_sof8 = 1'b0; s_last8 = 1'b0;
    collect8(crc, len, ok, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout got=%b want=0", to); end
    checks++; if (crc !== 32'hD202EF8D) begin errors++; $display("FAIL b2b_crc got=%h want=d202ef8d", crc); end
    checks++; if (len !== 16'd1) begin errors++; $display("FAIL b2b_len got=%0d want=1", len); end
    $display("back_to_back: second crc=%h len=%0d", crc, len);
  endtask

  task automatic test_abort();
    logic [31:0] crc; logic [15:0] len; logic ok, to;
    load_digits();
    beat8(8'h31, 1'b1, 1'b0, 1'b0);
    beat8(8'h32, 1'b0, 1'b0, 1'b0);
    beat8(8'h33, 1'b0, 1'b1, 1'b1);
    beat8(8'h00, 1'b1, 1'b1, 1'b1);
    beat8(8'h55, 1'b0, 1'b1, 1'b0);
    checks++; if (m_valid8 !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%b want=0", m_valid8); end
    frame8(9);
    collect8(crc, len, ok, to);
    checks++; if (crc !== 32'hCBF43926) begin errors++; $display("FAIL abort_crc got=%h want=cbf43926", crc); end
    checks++; if (len !== 16'd9) begin errors++; $display("FAIL abort_len got=%0d want=9", len); end
    repeat (3) @(posedge clk); #1;
    checks++; if (m_valid8 !== 1'b0) begin errors++; $display("FAIL abort_single_result got=%b want=0", m_valid8); end
    $display("abort: crc=%h len=%0d", crc, len);
    beat8(8'h31, 1'b1, 1'b0, 1'b0);
    beat8(8'h32, 1'b0, 1'b0, 1'b0);
    frame8(9);
    collect8(crc, len, ok, to);
    checks++; if (crc !== 32'hCBF43926) begin errors++; $display("FAIL restart_crc got=%h want=cbf43926", crc); end
    checks++; if (len !== 16'd9) begin errors++; $display("FAIL restart_len got=%0d want=9", len); end
    $display("sof restart: crc=%h len=%0d", crc, len);
  endtask

  task automatic test_rst_midframe();
    logic [31:0] crc; logic [15:0] len; logic ok, to;
    beat8(8'h31, 1'b1, 1'b0, 1'b0);
    beat8(8'h32, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    checks++; if (m_valid8 !== 1'b0) begin errors++; $display("FAIL rst_run_valid got=%b want=0", m_valid8); end
    beat8(8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (m_valid8 !== 1'b1) begin errors++; $display("FAIL rst_pre_hold_valid got=%b want=1", m_valid8); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    checks++; if (m_valid8 !== 1'b0 || m_crc8 !== 32'h0 || m_len8 !== 16'd0)
      begin errors++; $display("FAIL rst_hold_clear got=%b/%h/%0d want=0/00000000/0", m_valid8, m_crc8, m_len8); end
    beat8(8'h00, 1'b1, 1'b1, 1'b0);
    collect8(crc, len, ok, to);
    checks++; if (crc !== 32'hD202EF8D) begin errors++; $display("FAIL rst_next_crc got=%h want=d202ef8d", crc); end
    checks++; if (len !== 16'd1) begin errors++; $display("FAIL rst_next_len got=%0d want=1", len); end
    $display("rst midframe: next crc=%h len=%0d", crc, len);
  endtask

  initial begin
    rst = 1'b1;
    s_valid8 = 1'b0; s_data8 = 8'h0; s_sof8 = 1'b0; s_last8 = 1'b0; s_abort8 = 1'b0; m_ready8 = 1'b0;
    s_valid4 = 1'b0; s_data4 = 4'h0; s_sof4 = 1'b0; s_last4 = 1'b0; s_abort4 = 1'b0; m_ready4 = 1'b0;
    test_reset();
    test_basic8();
    test_nibble4();
    test_fcs();
    test_back_to_back();
    test_abort();
    test_rst_midframe();
    checks++; if (stall_to !== 0) begin errors++; $display("FAIL s_ready_stall got=%0d want=0", stall_to); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
